fpga_func_top: RTL and testbench

UART-controlled FPGA function block: a byte-oriented command processor behind an 8N1 UART that programs and reads back a banked byte memory, controls a held-in-reset flag, loops bytes back, and exchanges payload bytes with the 112-bit GPIO ports. It is the top-level functional core of the FPGA image. The board wrapper supplies only the clock, reset, GPIO pins and UART pins.

---
 rtl/fpga_func_pkg.sv | 31 +++
 rtl/fpga_func_if.sv | 24 ++
 rtl/uart_8n1.sv | 184 ++++++++++++++++++
 rtl/fpga_func_top.sv | 217 +++++++++++++++++++++
 tb/tb_fpga_func_top.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fpga_func_pkg.sv
// Shared constants and types for the UART-controlled FPGA function block.
package fpga_func_pkg;

    localparam int unsigned GPIO_W      = 112;
    localparam int unsigned GPIO_BYTES  = GPIO_W / 8;
    localparam int unsigned NUM_REGIONS = 8;
    localparam int unsigned SEL_W       = $clog2(NUM_REGIONS);
    localparam int unsigned LEN_W       = 16;
    localparam int unsigned HCNT_W      = 3;
    localparam int unsigned BIDX_W      = 4;

    localparam logic [3:0] OP_RST     = 4'h1;
    localparam logic [7:0] OP_RST_CLR = 8'h10;
    localparam logic [7:0] OP_RST_SET = 8'h1F;
    localparam logic [7:0] OP_LOOP    = 8'h20;
    localparam logic [7:0] OP_WR      = 8'h30;
    localparam logic [7:0] OP_RD      = 8'h40;
    localparam logic [7:0] OP_COMM    = 8'h50;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_WDATA,
        ST_RDATA,
        ST_LOOP,
        ST_CLEN,
        ST_CDATA,
        ST_CREPLY
    } parse_state_e;

endpackage

// File: rtl/fpga_func_if.sv
// Board-facing pins of the function block: GPIO ports and the UART line pair.
interface fpga_func_if;
    import fpga_func_pkg::*;

    logic [GPIO_W-1:0] gpio_out;
    logic [GPIO_W-1:0] gpio_in;
    logic              uart_rx_in;
    logic              uart_tx_out;

    modport master (
        input  gpio_out,
        input  uart_tx_out,
        output gpio_in,
        output uart_rx_in
    );

    modport slave (
        output gpio_out,
        output uart_tx_out,
        input  gpio_in,
        input  uart_rx_in
    );

endinterface

// File: rtl/uart_8n1.sv
// 8N1 UART receive and transmit engines sharing one bit-period parameter.
module uart_8n1 #(
    parameter int unsigned CLKS_PER_BIT = 36
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic       tx_out,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    uart_state_e      rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_valid_q, rx_valid_d;

    uart_state_e      tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_out_q, tx_out_d;
    logic             tx_fire_c;

    assign rx_data  = rx_shift_q;
    assign rx_valid = rx_valid_q;
    assign tx_out   = tx_out_q;

    // Start confirmed at half a bit, data sampled mid-bit, bad stop drops the byte.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        case (rx_state_q)
            U_IDLE: begin
                if (!rx_sync_q && rx_prev_q) begin
                    rx_state_d = U_START;
                    rx_cnt_d   = '0;
                end
            end
            U_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? U_IDLE : U_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            U_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = U_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            U_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_valid_d = rx_sync_q;
                    rx_state_d = U_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = U_IDLE;
        endcase
    end

    // Ready also in the last stop-bit cycle so queued bytes go out back-to-back.
    assign tx_ready  = (tx_state_q == U_IDLE) ||
                       ((tx_state_q == U_STOP) && (tx_cnt_q == BIT_LAST));
    assign tx_fire_c = tx_valid && tx_ready;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_out_d   = tx_out_q;
        case (tx_state_q)
            U_IDLE: begin
                if (tx_fire_c) begin
                    tx_state_d = U_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_data;
                    tx_out_d   = 1'b0;
                end
            end
            U_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = U_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_out_d   = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            U_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = U_STOP;
                        tx_out_d   = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_out_d   = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            U_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_fire_c) begin
                        tx_state_d = U_START;
                        tx_shift_d = tx_data;
                        tx_out_d   = 1'b0;
                    end else begin
                        tx_state_d = U_IDLE;
                        tx_out_d   = 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: tx_state_d = U_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= U_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            tx_state_q <= U_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_out_q   <= 1'b1;
        end else begin
            rx_meta_q  <= rx_in;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_out_q   <= tx_out_d;
        end
    end

endmodule

// File: rtl/fpga_func_top.sv
// Command processor behind the UART: banked byte memory, reset flag, loopback
// and GPIO payload exchange.
module fpga_func_top
    import fpga_func_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 36,
    parameter int unsigned MEM_AW       = 10
) (
    input logic        clk,
    input logic        rstn,
    fpga_func_if.slave pins
);

    localparam int unsigned MEM_DEPTH = NUM_REGIONS << MEM_AW;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_ready;
    logic       tx_busy_c;
    logic       slot_free_c;
    logic       mem_we_c;

    parse_state_e       state_q, state_d;
    logic [HCNT_W-1:0]  hdr_cnt_q, hdr_cnt_d;
    logic               is_rd_q, is_rd_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [MEM_AW-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [GPIO_W-1:0]  comm_q, comm_d;
    logic [GPIO_W-1:0]  snap_q, snap_d;
    logic [BIDX_W-1:0]  idx_q, idx_d;
    logic               core_rst_q, core_rst_d;
    logic [GPIO_W-1:0]  gpio_out_q, gpio_out_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;

    logic [7:0] mem [MEM_DEPTH];
    logic [7:0] mem_rdata_q;

    uart_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk      (clk),
        .rst      (rstn),
        .rx_in    (pins.uart_rx_in),
        .tx_out   (pins.uart_tx_out),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data_q),
        .tx_valid (tx_valid_q),
        .tx_ready (tx_ready)
    );

    assign pins.gpio_out = gpio_out_q;
    assign tx_busy_c     = tx_valid_q || !tx_ready;
    assign slot_free_c   = !tx_valid_q || tx_ready;

    // Read port follows the next address, so mem_rdata_q always matches {sel_q, addr_q}.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[{sel_q, addr_q}] <= rx_data;
        end
        mem_rdata_q <= mem[{sel_d, addr_d}];
    end

    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        is_rd_d    = is_rd_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        comm_d     = comm_q;
        snap_d     = snap_q;
        idx_d      = idx_q;
        core_rst_d = core_rst_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q && !tx_ready;
        mem_we_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // New commands are only taken once any reply has fully drained.
                if (rx_valid && !tx_busy_c) begin
                    hdr_cnt_d = '0;
                    addr_d    = '0;
                    cnt_d     = '0;
                    if (rx_data[7:4] == OP_RST) begin
                        if (rx_data == OP_RST_CLR) begin
                            core_rst_d = 1'b0;
                        end else if (rx_data == OP_RST_SET) begin
                            core_rst_d = 1'b1;
                        end
                    end else if (rx_data == OP_LOOP) begin
                        state_d = ST_LOOP;
                    end else if ((rx_data == OP_WR) || (rx_data == OP_RD)) begin
                        state_d = ST_HDR;
                        is_rd_d = (rx_data == OP_RD);
                    end else if (rx_data == OP_COMM) begin
                        state_d = ST_CLEN;
                    end
                end
            end
            ST_HDR: begin
                if (rx_valid) begin
                    hdr_cnt_d = hdr_cnt_q + HCNT_W'(1);
                    case (hdr_cnt_q)
                        3'd0:    sel_d  = rx_data[SEL_W-1:0];
                        3'd1,
                        3'd2:    addr_d = MEM_AW'({addr_q, rx_data});
                        default: cnt_d  = {cnt_q[7:0], rx_data};
                    endcase
                    if (hdr_cnt_q == 3'd4) begin
                        state_d = is_rd_q ? ST_RDATA : ST_WDATA;
                    end
                end
            end
            ST_WDATA: begin
                if (rx_valid) begin
                    mem_we_c = 1'b1;
                    addr_d   = addr_q + MEM_AW'(1);
                    cnt_d    = cnt_q - LEN_W'(1);
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RDATA: begin
                if (slot_free_c) begin
                    tx_data_d  = mem_rdata_q;
                    tx_valid_d = 1'b1;
                    addr_d     = addr_q + MEM_AW'(1);
                    cnt_d      = cnt_q - LEN_W'(1);
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_LOOP: begin
                if (rx_valid) begin
                    tx_data_d  = rx_data;
                    tx_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_CLEN: begin
                if (rx_valid) begin
                    cnt_d     = {cnt_q[7:0], rx_data};
                    len_d     = {cnt_q[7:0], rx_data};
                    hdr_cnt_d = hdr_cnt_q + HCNT_W'(1);
                    if (hdr_cnt_q == 3'd1) begin
                        state_d = ST_CDATA;
                    end
                end
            end
            ST_CDATA: begin
                if (rx_valid) begin
                    comm_d = {comm_q[GPIO_W-9:0], rx_data};
                    cnt_d  = cnt_q - LEN_W'(1);
                    if (cnt_q == '0) begin
                        snap_d  = pins.gpio_in;
                        cnt_d   = len_q;
                        idx_d   = '0;
                        state_d = ST_CREPLY;
                    end
                end
            end
            ST_CREPLY: begin
                if (slot_free_c) begin
                    tx_data_d  = snap_q[{idx_q, 3'b000} +: 8];
                    tx_valid_d = 1'b1;
                    idx_d      = (idx_q == BIDX_W'(GPIO_BYTES - 1)) ? '0 : idx_q + BIDX_W'(1);
                    cnt_d      = cnt_q - LEN_W'(1);
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        gpio_out_d = core_rst_d ? '0 : comm_d;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q    <= ST_IDLE;
            hdr_cnt_q  <= '0;
            is_rd_q    <= 1'b0;
            sel_q      <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            comm_q     <= '0;
            snap_q     <= '0;
            idx_q      <= '0;
            core_rst_q <= 1'b1;
            gpio_out_q <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_cnt_q  <= hdr_cnt_d;
            is_rd_q    <= is_rd_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            comm_q     <= comm_d;
            snap_q     <= snap_d;
            idx_q      <= idx_d;
            core_rst_q <= core_rst_d;
            gpio_out_q <= gpio_out_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

endmodule

// File: tb/tb_fpga_func_top.sv
// Directed bench for fpga_func_top: drives UART commands, decodes replies on the TX line.
module tb_fpga_func_top;
    import fpga_func_pkg::*;

    localparam int unsigned CPB = 36;
    localparam int unsigned AW  = 10;

    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] rxq[$];
    logic [7:0] expq[$];
    logic [GPIO_W-1:0] g_exp;

    fpga_func_if pins();

    fpga_func_top #(.CLKS_PER_BIT(CPB), .MEM_AW(AW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .pins (pins)
    );

    always #5 clk = ~clk;

    // TX line decoder: every frame seen is pushed to rxq.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (pins.uart_tx_out === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = pins.uart_tx_out;
                end
                repeat (CPB) @(negedge clk);
                rxq.push_back(b);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        pins.uart_rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            pins.uart_rx_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        pins.uart_rx_in = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [7:0] sel,
                            input logic [15:0] addr, input logic [15:0] len);
        send_byte(op);
        send_byte(sel);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        send_byte(len[15:8]);
        send_byte(len[7:0]);
    endtask

    task automatic chk(input string tag, input logic [GPIO_W-1:0] obs, input logic [GPIO_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the expected reply, then checks count and each byte.
    task automatic check_reply(input string tag);
        int t;
        int n;
        logic [7:0] obs;
        n = expq.size();
        t = 0;
        while ((rxq.size() < n) && (t < n * 10 * CPB + 1000)) begin
            @(negedge clk);
            t++;
        end
        repeat (800) @(negedge clk);
        total++;
        assert (rxq.size() === n) else begin
            bad++;
            $error("FAIL %s count: observed=%0d expected=%0d", tag, rxq.size(), n);
        end
        for (int i = 0; i < n; i++) begin
            obs = (i < rxq.size()) ? rxq[i] : 8'hxx;
            total++;
            assert (obs === expq[i]) else begin
                bad++;
                $error("FAIL %s byte%0d: observed=%0h expected=%0h", tag, i, obs, expq[i]);
            end
        end
        rxq.delete();
        expq.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
    endtask

    initial begin
        pins.gpio_in    = '0;
        pins.uart_rx_in = 1'b1;
        rstn            = 1'b1;
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_tx", GPIO_W'(pins.uart_tx_out), GPIO_W'(1));
        chk("reset_gpio", pins.gpio_out, '0);

        send_byte(8'h20);
        send_byte(8'hA5);
        expq = '{8'hA5};
        check_reply("loop_a5");

        send_hdr(OP_WR, 8'h03, 16'h0000, 16'h0007);
        for (int i = 0; i < 8; i++) send_byte(8'(i));
        send_hdr(OP_RD, 8'h03, 16'h0000, 16'h0007);
        for (int i = 0; i < 8; i++) expq.push_back(8'(i));
        check_reply("rd_r3");

        send_hdr(OP_WR, 8'h06, 16'h0000, 16'h0007);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i));
        send_hdr(OP_RD, 8'h06, 16'h0000, 16'h0007);
        for (int i = 0; i < 8; i++) expq.push_back(8'(8'h10 + i));
        check_reply("rd_r6");
        send_hdr(OP_RD, 8'h03, 16'h0000, 16'h0007);
        for (int i = 0; i < 8; i++) expq.push_back(8'(i));
        check_reply("rd_r3_again");

        send_hdr(OP_WR, 8'h01, 16'h03FF, 16'h0001);
        send_byte(8'hC1);
        send_byte(8'hC2);
        send_hdr(OP_RD, 8'h01, 16'h03FF, 16'h0001);
        expq = '{8'hC1, 8'hC2};
        check_reply("rd_wrap");
        // Upper sel and address bits are don't-care: this reads region 1 address 0.
        send_hdr(OP_RD, 8'hF9, 16'hFC00, 16'h0000);
        expq = '{8'hC2};
        check_reply("rd_addr0");

        pins.gpio_in = GPIO_W'(16'h2211);
        send_byte(8'h10);
        send_byte(8'h50);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hA5);
        send_byte(8'h5A);
        chk("gpio_comm", pins.gpio_out, GPIO_W'(16'hA55A));
        expq = '{8'h11, 8'h22};
        check_reply("comm_reply");
        send_byte(8'h1F);
        chk("gpio_core_rst", pins.gpio_out, '0);
        send_byte(8'h10);
        chk("gpio_release", pins.gpio_out, GPIO_W'(16'hA55A));

        for (int k = 0; k < 14; k++) pins.gpio_in[8*k +: 8] = 8'(k + 1);
        send_byte(8'h50);
        send_byte(8'h00);
        send_byte(8'h0E);
        for (int i = 0; i < 15; i++) send_byte(8'(8'h80 + i));
        for (int j = 0; j < 14; j++) g_exp[8*(13-j) +: 8] = 8'(8'h81 + j);
        chk("gpio_comm15", pins.gpio_out, g_exp);
        for (int k = 0; k < 14; k++) expq.push_back(8'(k + 1));
        expq.push_back(8'h01);
        check_reply("comm_wrap14");

        send_byte(8'h77);
        send_byte(8'h20);
        send_byte(8'h3C);
        expq = '{8'h3C};
        check_reply("unknown_then_loop");

        send_byte(8'h20);
        send_byte(8'h00);
        repeat (20) @(negedge clk);
        chk("echo_started", GPIO_W'(pins.uart_tx_out), GPIO_W'(0));
        pulse_reset();
        chk("abort_tx", GPIO_W'(pins.uart_tx_out), GPIO_W'(1));
        chk("abort_gpio", pins.gpio_out, '0);
        repeat (500) @(negedge clk);
        rxq.delete();

        send_byte(8'h30);
        send_byte(8'h01);
        pulse_reset();
        repeat (5) @(negedge clk);
        send_byte(8'h20);
        send_byte(8'h5A);
        expq = '{8'h5A};
        check_reply("loop_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
